sample_dma: RTL and testbench

//  Drains the sampler's sample FIFO (clk_48 read side) and writes each 16-bit sample into SDRAM

---
 rtl/sample_dma_pkg.sv | 28 ++
 rtl/sample_dma.sv | 183 ++++++++++++++++++
 tb/tb_sample_dma.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_dma_pkg.sv
// Shared constants for sample_dma: register map, CTRL/STATUS bit positions, FSM encodings.
package sample_dma_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned FSM_W  = 2;

    localparam logic [REG_AW-1:0] REG_CTRL   = 5'h00;
    localparam logic [REG_AW-1:0] REG_BASE   = 5'h04;
    localparam logic [REG_AW-1:0] REG_LIMIT  = 5'h08;
    localparam logic [REG_AW-1:0] REG_WPTR   = 5'h0C;
    localparam logic [REG_AW-1:0] REG_STATUS = 5'h10;
    localparam logic [REG_AW-1:0] REG_COUNT  = 5'h14;

    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_WRAP = 1;
    localparam int unsigned CTRL_CLR  = 2;

    localparam int unsigned STAT_BUSY    = 0;
    localparam int unsigned STAT_DONE    = 1;
    localparam int unsigned STAT_WRAPPED = 2;
    localparam int unsigned STAT_ERR     = 3;

    localparam logic [FSM_W-1:0] S_IDLE = 2'd0;
    localparam logic [FSM_W-1:0] S_RD   = 2'd1;
    localparam logic [FSM_W-1:0] S_CAP  = 2'd2;
    localparam logic [FSM_W-1:0] S_WR   = 2'd3;

endpackage

// File: rtl/sample_dma.sv
// Sample FIFO -> SDRAM writer with CPU-visible ring / one-shot buffer registers.
module sample_dma
    import sample_dma_pkg::*;
#(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk_48,
    input  logic              rst_n,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic [ADDR_W-1:0] awaddr,
    output logic [DATA_W-1:0] wdata,
    output logic              wvalid,
    input  logic              wready,
    input  logic [4:0]        waddr,
    input  logic [31:0]       wdata_cfg,
    input  logic              wvalid_cfg,
    input  logic [4:0]        araddr,
    input  logic              arvalid,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic              busy
);

    logic [FSM_W-1:0]  state;
    logic [FSM_W-1:0]  state_nxt;
    logic              ctrl_en;
    logic              ctrl_wrap;
    logic              done;
    logic              wrapped;
    logic              err;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] limit;
    logic [ADDR_W-1:0] wptr;
    logic [CNT_W-1:0]  count;

    logic [ADDR_W-1:0] wptr_inc_c;
    logic              accept_c;
    logic              last_c;
    logic              stop_c;
    logic              ctrl_wr_c;
    logic              en_start_c;
    logic              en_nxt_c;
    logic [31:0]       rdata_c;
    logic              unused_cfg_c;

    // Upper config bits are wider than any register field.
    assign unused_cfg_c = ^wdata_cfg[31:ADDR_W];

    // Enable or an in-flight word keeps the block busy.
    assign busy = ctrl_en || (state != S_IDLE);

    // Next-state, accept and next-enable decode.
    always_comb begin
        state_nxt  = state;
        wptr_inc_c = wptr + ADDR_W'(1);
        accept_c   = wvalid && wready;
        last_c     = (wptr_inc_c == limit);
        stop_c     = accept_c && last_c && !ctrl_wrap;
        ctrl_wr_c  = wvalid_cfg && (waddr == REG_CTRL);
        en_start_c = ctrl_wr_c && wdata_cfg[CTRL_EN] && !ctrl_en;
        en_nxt_c   = ctrl_en;
        if (ctrl_wr_c) begin
            en_nxt_c = wdata_cfg[CTRL_EN] && (ctrl_en || (limit > base));
        end
        if (stop_c) begin
            en_nxt_c = 1'b0;
        end
        case (state)
            S_IDLE:  if (en_nxt_c && !fifo_empty) state_nxt = S_RD;
            S_RD:    state_nxt = S_CAP;
            S_CAP:   state_nxt = S_WR;
            S_WR:    if (accept_c) state_nxt = (en_nxt_c && !fifo_empty) ? S_RD : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_48) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Register file, write pointer/count and registered bus outputs; later assignments take priority.
    always_ff @(posedge clk_48) begin
        if (!rst_n) begin
            fifo_rd   <= 1'b0;
            awaddr    <= '0;
            wdata     <= '0;
            wvalid    <= 1'b0;
            rdata     <= '0;
            rvalid    <= 1'b0;
            ctrl_en   <= 1'b0;
            ctrl_wrap <= 1'b0;
            done      <= 1'b0;
            wrapped   <= 1'b0;
            err       <= 1'b0;
            base      <= '0;
            limit     <= '0;
            wptr      <= '0;
            count     <= '0;
        end else begin
            fifo_rd <= (state_nxt == S_RD);
            if (state == S_CAP) begin
                wdata  <= fifo_rd_data;
                awaddr <= wptr;
                wvalid <= 1'b1;
            end else if (accept_c) begin
                wvalid <= 1'b0;
            end

            ctrl_en <= en_nxt_c;
            if (ctrl_wr_c) begin
                ctrl_wrap <= wdata_cfg[CTRL_WRAP];
                if (wdata_cfg[CTRL_CLR]) begin
                    done    <= 1'b0;
                    wrapped <= 1'b0;
                    err     <= 1'b0;
                end
                if (en_start_c) begin
                    if (limit <= base) begin
                        err <= 1'b1;
                    end else begin
                        wptr    <= base;
                        count   <= '0;
                        done    <= 1'b0;
                        wrapped <= 1'b0;
                    end
                end
            end
            if (wvalid_cfg && !busy) begin
                if (waddr == REG_BASE)  base  <= wdata_cfg[ADDR_W-1:0];
                if (waddr == REG_LIMIT) limit <= wdata_cfg[ADDR_W-1:0];
            end

            if (accept_c) begin
                if (count != '1) count <= count + CNT_W'(1);
                if (last_c) begin
                    if (ctrl_wrap) begin
                        wptr    <= base;
                        wrapped <= 1'b1;
                    end else begin
                        done <= 1'b1;
                    end
                end else begin
                    wptr <= wptr_inc_c;
                end
            end

            rvalid <= arvalid;
            if (arvalid) rdata <= rdata_c;
        end
    end

    // Register read mux; sampled from pre-write values.
    always_comb begin
        rdata_c = '0;
        case (araddr)
            REG_CTRL: begin
                rdata_c[CTRL_EN]   = ctrl_en;
                rdata_c[CTRL_WRAP] = ctrl_wrap;
            end
            REG_BASE:  rdata_c = 32'(base);
            REG_LIMIT: rdata_c = 32'(limit);
            REG_WPTR:  rdata_c = 32'(wptr);
            REG_STATUS: begin
                rdata_c[STAT_BUSY]    = busy;
                rdata_c[STAT_DONE]    = done;
                rdata_c[STAT_WRAPPED] = wrapped;
                rdata_c[STAT_ERR]     = err;
            end
            REG_COUNT: rdata_c = 32'(count);
            default:   rdata_c = '0;
        endcase
    end

endmodule

// File: tb/tb_sample_dma.sv
// Directed bench for sample_dma with a FIFO source model and an SDRAM write logger.
module tb_sample_dma;

    logic        clk_48 = 1'b0;
    logic        rst_n = 1'b0;
    logic        fifo_empty;
    logic        fifo_rd;
    logic [15:0] fifo_rd_data = '0;
    logic [23:0] awaddr;
    logic [15:0] wdata;
    logic        wvalid;
    logic        wready = 1'b1;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata_cfg = '0;
    logic        wvalid_cfg = 1'b0;
    logic [4:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] fifo_mem [0:63];
    int          wr_idx = 0;
    int          rd_idx = 0;
    logic [23:0] log_addr [0:63];
    logic [15:0] log_data [0:63];
    int          n_wr = 0;
    int          n_rd = 0;

    sample_dma dut (
        .clk_48(clk_48), .rst_n(rst_n),
        .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .fifo_rd_data(fifo_rd_data),
        .awaddr(awaddr), .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .waddr(waddr), .wdata_cfg(wdata_cfg), .wvalid_cfg(wvalid_cfg),
        .araddr(araddr), .arvalid(arvalid), .rdata(rdata), .rvalid(rvalid),
        .busy(busy)
    );

    always #5 clk_48 = ~clk_48;

    assign fifo_empty = (wr_idx == rd_idx);

    // FIFO read side and SDRAM write acceptance log.
    always @(posedge clk_48) begin
        if (fifo_rd) begin
            n_rd <= n_rd + 1;
            if (rd_idx != wr_idx) begin
                fifo_rd_data <= fifo_mem[rd_idx[5:0]];
                rd_idx       <= rd_idx + 1;
            end
        end
        if (wvalid && wready) begin
            log_addr[n_wr[5:0]] <= awaddr;
            log_data[n_wr[5:0]] <= wdata;
            n_wr <= n_wr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [15:0] d);
        fifo_mem[wr_idx[5:0]] = d;
        wr_idx = wr_idx + 1;
    endtask

    task automatic cfg_wr(input logic [4:0] a, input logic [31:0] d);
        waddr = a; wdata_cfg = d; wvalid_cfg = 1'b1;
        @(posedge clk_48); #1;
        wvalid_cfg = 1'b0;
    endtask

    task automatic cfg_rd(input logic [4:0] a, output logic [31:0] d);
        araddr = a; arvalid = 1'b1;
        @(posedge clk_48); #1;
        arvalid = 1'b0;
        d = rdata;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        cfg_rd(a, d);
        chk(tag, d, exp);
    endtask

    task automatic wait_idle(input string tag, input int max);
        for (int i = 0; i < max && busy; i++) begin
            @(posedge clk_48); #1;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_wvalid(input string tag, input int max);
        for (int i = 0; i < max && !wvalid; i++) begin
            @(posedge clk_48); #1;
        end
        chk(tag, 32'(wvalid), 32'd1);
    endtask

    task automatic wait_writes(input string tag, input int target, input int max);
        for (int i = 0; i < max && n_wr < target; i++) begin
            @(posedge clk_48); #1;
        end
        chk(tag, 32'(n_wr), 32'(target));
    endtask

    initial begin
        int          wr0;
        int          rd0;
        logic [23:0] a0;
        logic [15:0] d0;
        logic        stable;
        logic [23:0] exp_a [0:5];
        exp_a = '{24'h100, 24'h101, 24'h102, 24'h103, 24'h100, 24'h101};

        // Reset values
        repeat (3) @(posedge clk_48);
        #1;
        chk("rst_wvalid", 32'(wvalid), 32'd0);
        chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_awaddr", 32'(awaddr), 32'd0);
        rst_n = 1'b1;
        @(posedge clk_48); #1;
        rd_chk("rst_status", REG_STATUS_A(), 32'd0);
        chk("rvalid_pulse", 32'(rvalid), 32'd1);
        @(posedge clk_48); #1;
        chk("rvalid_clear", 32'(rvalid), 32'd0);

        // 1: one-shot, 4 words
        wr0 = n_wr; rd0 = n_rd;
        for (int i = 0; i < 4; i++) push(16'hA000 + 16'(i));
        cfg_wr(5'h04, 32'h100);
        cfg_wr(5'h08, 32'h104);
        cfg_wr(5'h00, 32'h1);
        wait_idle("t1_idle", 200);
        chk("t1_nwr", 32'(n_wr - wr0), 32'd4);
        chk("t1_nrd", 32'(n_rd - rd0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t1_addr", 32'(log_addr[wr0 + i]), 32'h100 + 32'(i));
            chk("t1_data", 32'(log_data[wr0 + i]), 32'hA000 + 32'(i));
        end
        rd_chk("t1_status", 5'h10, 32'h2);
        rd_chk("t1_ctrl", 5'h00, 32'h0);
        rd_chk("t1_count", 5'h14, 32'd4);

        // 2: ring, 6 words
        wr0 = n_wr;
        for (int i = 0; i < 6; i++) push(16'hB000 + 16'(i));
        cfg_wr(5'h00, 32'h3);
        wait_writes("t2_nwr", wr0 + 6, 200);
        cfg_wr(5'h00, 32'h2);
        wait_idle("t2_idle", 50);
        for (int i = 0; i < 6; i++) begin
            chk("t2_addr", 32'(log_addr[wr0 + i]), 32'(exp_a[i]));
            chk("t2_data", 32'(log_data[wr0 + i]), 32'hB000 + 32'(i));
        end
        rd_chk("t2_status", 5'h10, 32'h4);
        rd_chk("t2_wptr", 5'h0C, 32'h102);
        rd_chk("t2_count", 5'h14, 32'd6);

        // 3: wready stall, stable outputs
        wready = 1'b0;
        rd0 = n_rd; wr0 = n_wr;
        push(16'hC0DE);
        cfg_wr(5'h00, 32'h5);
        wait_wvalid("t3_wvalid", 50);
        a0 = awaddr; d0 = wdata; stable = 1'b1;
        repeat (10) begin
            @(posedge clk_48); #1;
            if (!wvalid || awaddr != a0 || wdata != d0) stable = 1'b0;
        end
        chk("t3_stable", 32'(stable), 32'd1);
        chk("t3_addr", 32'(a0), 32'h100);
        chk("t3_data", 32'(d0), 32'hC0DE);
        chk("t3_nrd", 32'(n_rd - rd0), 32'd1);
        wready = 1'b1;
        @(posedge clk_48); #1;
        chk("t3_nwr", 32'(n_wr - wr0), 32'd1);
        chk("t3_wvalid_low", 32'(wvalid), 32'd0);

        // 4: disable during WR
        wready = 1'b0;
        wr0 = n_wr; rd0 = n_rd;
        push(16'hD001);
        push(16'hD002);
        wait_wvalid("t4_wvalid", 50);
        cfg_wr(5'h04, 32'h300);
        cfg_wr(5'h00, 32'h0);
        repeat (3) @(posedge clk_48);
        #1;
        chk("t4_held", 32'(wvalid), 32'd1);
        wready = 1'b1;
        wait_idle("t4_idle", 50);
        repeat (4) @(posedge clk_48);
        #1;
        chk("t4_nwr", 32'(n_wr - wr0), 32'd1);
        chk("t4_addr", 32'(log_addr[wr0]), 32'h101);
        chk("t4_data", 32'(log_data[wr0]), 32'hD001);
        chk("t4_level", 32'(wr_idx - rd_idx), 32'd1);
        chk("t4_nrd", 32'(n_rd - rd0), 32'd1);
        rd_chk("t4_base_locked", 5'h04, 32'h100);

        // 5: bad window -> err, W1 clear, set-wins, read-before-write
        rd0 = n_rd;
        cfg_wr(5'h04, 32'h200);
        cfg_wr(5'h08, 32'h200);
        cfg_wr(5'h00, 32'h1);
        repeat (5) @(posedge clk_48);
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_nrd", 32'(n_rd - rd0), 32'd0);
        rd_chk("t5_err", 5'h10, 32'h8);
        cfg_wr(5'h00, 32'h4);
        rd_chk("t5_clr", 5'h10, 32'h0);
        cfg_wr(5'h00, 32'h5);
        rd_chk("t5_setwins", 5'h10, 32'h8);
        cfg_wr(5'h00, 32'h4);
        rd_chk("t5_clr2", 5'h10, 32'h0);
        waddr = 5'h08; wdata_cfg = 32'h555; wvalid_cfg = 1'b1;
        araddr = 5'h08; arvalid = 1'b1;
        @(posedge clk_48); #1;
        wvalid_cfg = 1'b0; arvalid = 1'b0;
        chk("t5_rdw_old", rdata, 32'h200);
        rd_chk("t5_rdw_new", 5'h08, 32'h555);

        // 6: reset during WR
        wready = 1'b0;
        wr0 = n_wr;
        cfg_wr(5'h04, 32'h100);
        cfg_wr(5'h08, 32'h104);
        cfg_wr(5'h00, 32'h1);
        wait_wvalid("t6_wvalid", 50);
        chk("t6_data", 32'(wdata), 32'hD002);
        rst_n = 1'b0;
        @(posedge clk_48); #1;
        rst_n = 1'b1;
        chk("t6_wvalid", 32'(wvalid), 32'd0);
        chk("t6_fifo_rd", 32'(fifo_rd), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_awaddr", 32'(awaddr), 32'd0);
        chk("t6_wdata", 32'(wdata), 32'd0);
        rd_chk("t6_ctrl", 5'h00, 32'h0);
        rd_chk("t6_base", 5'h04, 32'h0);
        rd_chk("t6_limit", 5'h08, 32'h0);
        rd_chk("t6_wptr", 5'h0C, 32'h0);
        rd_chk("t6_count", 5'h14, 32'h0);
        wready = 1'b1;
        repeat (5) @(posedge clk_48);
        #1;
        chk("t6_nwr", 32'(n_wr - wr0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    function automatic logic [4:0] REG_STATUS_A();
        return 5'h10;
    endfunction

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
